// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch stage with a one-entry skid register and delayed-branch redirect.
// Latency: instr/instrPC become valid one cycle after the memReady that completes the read.
// Backpressure: stall freezes the instr outputs; a read that finishes under stall parks in the skid.
// Ports: clk, rst (async, active low); stall, shouldUseNewPC, branchTo from decode/branch unit;
//        memReq, memAddr, memReady, memData to instruction memory; instr, instrPC, instrValid,
//        pcAddress (instrPC+4) to decode/branch; addrError is a sticky misaligned-target flag.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        shouldUseNewPC,
  input  logic [31:0] branchTo,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  output logic        instrValid,
  output logic [31:0] pcAddress,
  output logic        addrError
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetchState_e;

  fetchState_e state;
  fetchState_e stateNext;

  logic [31:0] fetchPC;
  logic [31:0] nextPC;
  logic [31:0] pendingTarget;
  logic        pendingValid;
  logic [31:0] skidData;
  logic [31:0] skidAddr;

  logic complete;     // read finishes this cycle
  logic advance;      // a word moves into instr and fetchPC steps forward
  logic redirectSeen;
  logic redirectOk;
  logic redirectBad;

  assign memAddr   = fetchPC;
  assign pcAddress = instrPC + 32'd4;

  // Each valid instruction sees exactly one cycle with stall=0, so the redirect
  // request is sampled once per instruction.
  assign redirectSeen = instrValid && !stall && shouldUseNewPC;
  assign redirectOk   = redirectSeen && (branchTo[1:0] == 2'b00);
  assign redirectBad  = redirectSeen && (branchTo[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    memReq    = 1'b0;
    complete  = 1'b0;
    advance   = 1'b0;
    case (state)
      BOOT: begin
        stateNext = REQ;
      end
      REQ: begin
        memReq   = 1'b1;
        complete = memReady;
        if (memReady) begin
          if (stall) begin
            stateNext = HOLD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          advance   = 1'b1;
          stateNext = REQ;
        end
      end
      default: begin
        stateNext = BOOT;
      end
    endcase
  end

  // When a redirect is sampled in the same cycle the word behind the branch
  // (its delay slot) is delivered, the target goes straight into fetchPC.
  always_comb begin
    nextPC = fetchPC + 32'd4;
    if (redirectOk) begin
      nextPC = branchTo;
    end else if (pendingValid) begin
      nextPC = pendingTarget;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPC       <= RESET_PC;
      instr         <= 32'h0;
      instrPC       <= 32'h0;
      instrValid    <= 1'b0;
      pendingTarget <= 32'h0;
      pendingValid  <= 1'b0;
      skidData      <= 32'h0;
      skidAddr      <= 32'h0;
      addrError     <= 1'b0;
    end else begin
      if (advance) begin
        fetchPC    <= nextPC;
        instrValid <= 1'b1;
        if (state == HOLD) begin
          instr   <= skidData;
          instrPC <= skidAddr;
        end else begin
          instr   <= memData;
          instrPC <= fetchPC;
        end
      end else if (complete) begin
        // Completion without advance means decode is stalled: park the word.
        skidData <= memData;
        skidAddr <= fetchPC;
      end else if (state == REQ && !stall) begin
        instrValid <= 1'b0;
      end

      if (advance) begin
        pendingValid <= 1'b0;
      end else if (redirectOk) begin
        pendingValid  <= 1'b1;
        pendingTarget <= branchTo;
      end

      if (redirectBad) begin
        addrError <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: scenario tasks drive pc_fetch against a memory that returns ~addr.
// Latency: expected instruction addresses are queued up front and popped as decode consumes.
// Backpressure: stall is driven per scenario; consumption happens when instrValid=1 and stall=0.
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOBR     = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        shouldUseNewPC = 1'b0;
  logic [31:0] branchTo = 32'h0;
  logic        memReady = 1'b0;
  logic [31:0] memData = 32'h0;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic        instrValid;
  logic [31:0] pcAddress;
  logic        addrError;

  int tests = 0;
  int failures = 0;
  logic [31:0] expQ[$];

  pc_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .shouldUseNewPC(shouldUseNewPC),
    .branchTo      (branchTo),
    .memReq        (memReq),
    .memAddr       (memAddr),
    .memReady      (memReady),
    .memData       (memData),
    .instr         (instr),
    .instrPC       (instrPC),
    .instrValid    (instrValid),
    .pcAddress     (pcAddress),
    .addrError     (addrError)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs (caller is just past a negedge) and sample #1 later.
  task automatic tick(input logic st, input logic rdy, input logic [31:0] brPC,
                      input logic [31:0] brTgt, output logic consumed,
                      output logic [31:0] gotPC, output logic [31:0] gotInstr);
    stall          = st;
    memReady       = rdy;
    memData        = memAddr ^ 32'hFFFF_FFFF;
    shouldUseNewPC = instrValid && !st && (instrPC == brPC);
    branchTo       = brTgt;
    #1;
    consumed = instrValid && !st;
    gotPC    = instrPC;
    gotInstr = instr;
  endtask

  task automatic doReset();
    rst = 1'b0;
    stall = 1'b0;
    memReady = 1'b0;
    shouldUseNewPC = 1'b0;
    branchTo = 32'h0;
    memData = 32'h0;
    expQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    memReady = 1'b1;
    memData = 32'hDEAD_BEEF;
    #2;
    tests++;
    if (memReq !== 1'b0 || memAddr !== RESET_PC) begin
      failures++;
      $display("FAIL reset_mem got memReq=%b memAddr=%h want 0/%h", memReq, memAddr, RESET_PC);
    end
    tests++;
    if (instr !== 32'h0 || instrPC !== 32'h0 || instrValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_instr got instr=%h pc=%h vld=%b want 0/0/0", instr, instrPC, instrValid);
    end
    tests++;
    if (pcAddress !== 32'd4 || addrError !== 1'b0) begin
      failures++;
      $display("FAIL reset_misc got pcAddress=%h addrError=%b want 4/0", pcAddress, addrError);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (memReq !== 1'b0) begin
      failures++;
      $display("FAIL boot_memreq got %b want 0", memReq);
    end
    @(negedge clk);
    memData = memAddr ^ 32'hFFFF_FFFF;
    #1;
    tests++;
    if (memReq !== 1'b1 || memAddr !== RESET_PC) begin
      failures++;
      $display("FAIL first_req got memReq=%b memAddr=%h want 1/%h", memReq, memAddr, RESET_PC);
    end
    tests++;
    if (instrValid !== 1'b0) begin
      failures++;
      $display("FAIL boot_stray got instrValid=%b want 0", instrValid);
    end
    @(negedge clk);
    memReady = 1'b0;
    #1;
    tests++;
    if (instrValid !== 1'b1 || instrPC !== RESET_PC || instr !== ~RESET_PC) begin
      failures++;
      $display("FAIL first_latency got vld=%b pc=%h instr=%h want 1/%h/%h",
               instrValid, instrPC, instr, RESET_PC, ~RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic cons;
    logic [31:0] pc, ins, exp;
    logic seen = 1'b0;
    doReset();
    for (int a = 0; a <= 12; a += 4) expQ.push_back(32'(a));
    for (int c = 0; c < 12 && expQ.size() > 0; c++) begin
      @(negedge clk);
      tick(1'b0, 1'b1, NOBR, 32'h0, cons, pc, ins);
      if (seen) begin
        tests++;
        if (!cons) begin
          failures++;
          $display("FAIL stream_gap got instrValid=%b want 1", instrValid);
        end
      end
      if (cons) begin
        seen = 1'b1;
        exp = expQ.pop_front();
        tests++;
        if (pc !== exp || ins !== ~exp || pcAddress !== exp + 32'd4) begin
          failures++;
          $display("FAIL stream_seq got pc=%h instr=%h pcAddr=%h want %h/%h/%h",
                   pc, ins, pcAddress, exp, ~exp, exp + 32'd4);
        end
      end
    end
    tests++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL stream_missing got %0d left want 0", expQ.size());
    end
  endtask

  task automatic test_stall();
    logic cons;
    logic [31:0] pc, ins, exp, frozenPC, frozenInstr;
    int stallLeft = 0;
    logic stallDone = 1'b0;
    frozenPC = 32'h0;
    frozenInstr = 32'h0;
    doReset();
    for (int a = 0; a <= 32'h18; a += 4) expQ.push_back(32'(a));
    for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
      @(negedge clk);
      if (!stallDone && memReq && memAddr == 32'h10) begin
        stallLeft = 3;
        stallDone = 1'b1;
      end
      tick(stallLeft > 0, 1'b1, NOBR, 32'h0, cons, pc, ins);
      if (stallLeft == 3) begin
        frozenPC = instrPC;
        frozenInstr = instr;
      end else if (stallLeft > 0) begin
        tests++;
        if (memReq !== 1'b0 || instrPC !== frozenPC || instr !== frozenInstr || instrValid !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold got memReq=%b pc=%h instr=%h vld=%b want 0/%h/%h/1",
                   memReq, instrPC, instr, instrValid, frozenPC, frozenInstr);
        end
      end
      if (stallLeft > 0) stallLeft--;
      if (cons) begin
        exp = expQ.pop_front();
        tests++;
        if (pc !== exp || ins !== ~exp) begin
          failures++;
          $display("FAIL stall_seq got pc=%h instr=%h want %h/%h", pc, ins, exp, ~exp);
        end
      end
    end
    tests++;
    if (expQ.size() != 0 || !stallDone) begin
      failures++;
      $display("FAIL stall_missing got %0d left stalled=%b want 0/1", expQ.size(), stallDone);
    end
  endtask

  task automatic test_branch(input int delay);
    logic cons, rdy;
    logic [31:0] pc, ins, exp;
    int delayLeft;
    delayLeft = delay;
    doReset();
    for (int a = 0; a <= 32'h24; a += 4) expQ.push_back(32'(a));
    expQ.push_back(32'h100);
    expQ.push_back(32'h104);
    for (int c = 0; c < 60 && expQ.size() > 0; c++) begin
      @(negedge clk);
      rdy = 1'b1;
      if (memReq && memAddr == 32'h24 && delayLeft > 0) begin
        rdy = 1'b0;
        delayLeft--;
      end
      tick(1'b0, rdy, 32'h20, 32'h100, cons, pc, ins);
      if (cons) begin
        exp = expQ.pop_front();
        tests++;
        if (pc !== exp || ins !== ~exp) begin
          failures++;
          $display("FAIL branch_seq delay=%0d got pc=%h instr=%h want %h/%h", delay, pc, ins, exp, ~exp);
        end
      end
    end
    tests++;
    if (expQ.size() != 0 || delayLeft != 0) begin
      failures++;
      $display("FAIL branch_missing delay=%0d got %0d left want 0", delay, expQ.size());
    end
  endtask

  task automatic test_addr_error();
    logic cons;
    logic [31:0] pc, ins, exp;
    doReset();
    for (int a = 0; a <= 32'h2C; a += 4) expQ.push_back(32'(a));
    for (int c = 0; c < 40 && expQ.size() > 0; c++) begin
      @(negedge clk);
      tick(1'b0, 1'b1, 32'h20, 32'h102, cons, pc, ins);
      if (c == 2) begin
        tests++;
        if (addrError !== 1'b0) begin
          failures++;
          $display("FAIL addr_err_early got %b want 0", addrError);
        end
      end
      if (cons) begin
        exp = expQ.pop_front();
        tests++;
        if (pc !== exp || ins !== ~exp) begin
          failures++;
          $display("FAIL addr_err_seq got pc=%h instr=%h want %h/%h", pc, ins, exp, ~exp);
        end
      end
    end
    repeat (3) begin
      @(negedge clk);
      tick(1'b1, 1'b1, NOBR, 32'h0, cons, pc, ins);
    end
    tests++;
    if (addrError !== 1'b1 || expQ.size() != 0) begin
      failures++;
      $display("FAIL addr_err_sticky got addrError=%b left=%0d want 1/0", addrError, expQ.size());
    end
    rst = 1'b0;
    #1;
    tests++;
    if (addrError !== 1'b0) begin
      failures++;
      $display("FAIL addr_err_clear got %b want 0", addrError);
    end
  endtask

  task automatic test_reset_mid();
    logic cons;
    logic [31:0] pc, ins, exp;
    logic hit = 1'b0;
    doReset();
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      hit = memReq && (memAddr == 32'h40);
      tick(1'b0, !hit, NOBR, 32'h0, cons, pc, ins);
    end
    tests++;
    if (memReq !== 1'b1 || memAddr !== 32'h40) begin
      failures++;
      $display("FAIL mid_pending got memReq=%b memAddr=%h want 1/00000040", memReq, memAddr);
    end
    rst = 1'b0;
    memReady = 1'b1;
    memData = 32'hDEAD_BEEF;
    #1;
    tests++;
    if (memReq !== 1'b0 || memAddr !== RESET_PC || instrValid !== 1'b0) begin
      failures++;
      $display("FAIL mid_abort got memReq=%b memAddr=%h vld=%b want 0/%h/0",
               memReq, memAddr, instrValid, RESET_PC);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (memReq !== 1'b0) begin
      failures++;
      $display("FAIL mid_boot got memReq=%b want 0", memReq);
    end
    expQ.push_back(RESET_PC);
    expQ.push_back(RESET_PC + 32'd4);
    for (int c = 0; c < 12 && expQ.size() > 0; c++) begin
      @(negedge clk);
      tick(1'b0, 1'b1, NOBR, 32'h0, cons, pc, ins);
      if (cons) begin
        exp = expQ.pop_front();
        tests++;
        if (pc !== exp || ins !== ~exp) begin
          failures++;
          $display("FAIL mid_refetch got pc=%h instr=%h want %h/%h", pc, ins, exp, ~exp);
        end
      end
    end
    tests++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL mid_missing got %0d left want 0", expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch(0);
    test_branch(4);
    test_addr_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
